// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
package imem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam int          INSTR_STRIDE = 4;
  localparam int          STRIDE_SH    = $clog2(INSTR_STRIDE);

  // Even-parity bit for a word of up to 64 bits; zero-extension leaves parity unchanged.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_sram.sv
// Single-write-port storage with a one-cycle synchronous read, write-first on address collision.
module imem_sram #(
  parameter int DEPTH = 64,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // The array itself is never cleared so program images survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: one-cycle fetch port plus a burst program loader.
// Optional IMEM_PARITY_EN adds a stored even-parity bit per word and the par_err output.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_instr,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [XLEN-1:0]   load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_busy
`ifdef IMEM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = XLEN + 1;
`else
  localparam int MEM_W = XLEN;
`endif

  state_t           state;
  logic [IDX_W-1:0] wptr;
  logic             fetch_acc;
  logic             fault_p0;
  logic             re_p0;
  logic [IDX_W-1:0] ridx_p0;
  logic             we;
  logic [MEM_W-1:0] wdata;
  logic [MEM_W-1:0] rdata_p1;
  logic             vld_p1;
  logic             fault_p1;
  logic             unused_base;

  assign fetch_ready = (state == IDLE);
  assign load_ready  = (state == LOAD);
  assign load_busy   = (state == LOAD);
  assign unused_base = ^load_base;

  // Stage p0: request decode, range/alignment check, memory access issue
  assign fetch_acc = fetch_req & fetch_ready;
  assign fault_p0  = (fetch_addr[STRIDE_SH-1:0] != '0) ||
                     (64'(fetch_addr >> STRIDE_SH) >= 64'(DEPTH));
  assign ridx_p0   = fetch_addr[STRIDE_SH +: IDX_W];
  assign re_p0     = fetch_acc & ~fault_p0;
  assign we        = load_ready & load_valid;

`ifdef IMEM_PARITY_EN
  assign wdata = {even_parity(64'(load_data)), load_data};
`else
  assign wdata = load_data;
`endif

  imem_sram #(
    .DEPTH (DEPTH),
    .W     (MEM_W)
  ) u_sram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wptr),
    .wdata (wdata),
    .re    (re_p0),
    .raddr (ridx_p0),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wptr     <= '0;
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
    end else begin
      vld_p1 <= fetch_acc;
      if (fetch_acc) fault_p1 <= fault_p0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            wptr  <= load_base[STRIDE_SH +: IDX_W];
          end
        end
        LOAD: begin
          if (load_valid) begin
            wptr <= wptr + IDX_W'(1);
            if (load_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: response; the read register only moves on a real read, so the word is held between fetches
  assign fetch_valid = vld_p1;
  assign fetch_fault = fault_p1;
  assign fetch_instr = fault_p1 ? XLEN'(NOP_INSTR) : rdata_p1[XLEN-1:0];

`ifdef IMEM_PARITY_EN
  assign par_err = vld_p1 & ~fault_p1 & (^rdata_p1);
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: directed table, corner sequences and randomized traffic vs. a word-array model.
module tb_instr_mem_ctrl;

  localparam int DEPTH  = 64;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [XLEN-1:0]   fetch_instr;
  logic              fetch_fault;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic              load_valid;
  logic [XLEN-1:0]   load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_busy;
`ifdef IMEM_PARITY_EN
  logic              par_err;
`endif

  instr_mem_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_busy   (load_busy)
`ifdef IMEM_PARITY_EN
    ,
    .par_err     (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_fetch(input logic [31:0] addr, output logic [31:0] instr,
                                      output logic fault);
    if ((addr % 4) != 0 || (addr / 4) >= DEPTH) begin
      instr = NOP;
      fault = 1'b1;
    end else begin
      instr = model_mem[addr / 4];
      fault = 1'b0;
    end
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, " valid"}, fetch_valid, 0);
    check({name, " instr"}, fetch_instr, 0);
    check({name, " fault"}, fetch_fault, 0);
    check({name, " busy"}, load_busy, 0);
    check({name, " fready"}, fetch_ready, 1);
    check({name, " lready"}, load_ready, 0);
`ifdef IMEM_PARITY_EN
    check({name, " par_err"}, par_err, 0);
`endif
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] addr);
    logic [31:0] ei;
    logic        ef;
    model_fetch(addr, ei, ef);
    check({name, " ready"}, fetch_ready, 1);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    step();
    fetch_req  = 1'b0;
    fetch_addr = $urandom;
    check({name, " valid"}, fetch_valid, 1);
    check({name, " instr"}, fetch_instr, ei);
    check({name, " fault"}, fetch_fault, ef);
`ifdef IMEM_PARITY_EN
    check({name, " par_err"}, par_err, 0);
`endif
    step();
    check({name, " valid drop"}, fetch_valid, 0);
    check({name, " hold"}, fetch_instr, ei);
  endtask

  task automatic load_burst(input string name, input logic [31:0] base, input logic [31:0] words[$],
                            input bit gaps);
    int idx;
    idx = (base / 4) % DEPTH;
    load_start = 1'b1;
    load_base  = base;
    step();
    load_start = 1'b0;
    check({name, " busy start"}, load_busy, 1);
    check({name, " lready"}, load_ready, 1);
    check({name, " fready"}, fetch_ready, 0);
    for (int i = 0; i < words.size(); i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        load_valid = 1'b0;
        step();
        check({name, " busy gap"}, load_busy, 1);
      end
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == words.size() - 1);
      step();
      model_mem[idx] = words[i];
      idx = (idx + 1) % DEPTH;
      if (i != words.size() - 1) check({name, " busy mid"}, load_busy, 1);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check({name, " busy end"}, load_busy, 0);
    check({name, " fready end"}, fetch_ready, 1);
  endtask

  initial begin
    logic [31:0] q[$];
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_base  = '0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    #2;
    check_reset_outputs("reset");
    step();
    step();
    reset = 1'b0;
    step();

    // Basic two-word burst, then directed fetch table.
    q = '{32'h00948663, 32'h019806B3};
    load_burst("burst0", 32'h0, q, 1'b0);

    tbl[0] = '{"t_idx0",   32'h00000000, 32'h00948663, 1'b0};
    tbl[1] = '{"t_idx1",   32'h00000004, 32'h019806B3, 1'b0};
    tbl[2] = '{"t_mis6",   32'h00000006, NOP,          1'b1};
    tbl[3] = '{"t_mis1",   32'h00000001, NOP,          1'b1};
    tbl[4] = '{"t_oor100", 32'h00000100, NOP,          1'b1};
    tbl[5] = '{"t_oorhi",  32'hFFFFFFFC, NOP,          1'b1};
    tbl[6] = '{"t_mis3",   32'h00000003, NOP,          1'b1};
    for (int i = 0; i < 7; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = tbl[i].addr;
      step();
      fetch_req = 1'b0;
      check({tbl[i].name, " valid"}, fetch_valid, 1);
      check({tbl[i].name, " instr"}, fetch_instr, tbl[i].instr);
      check({tbl[i].name, " fault"}, fetch_fault, tbl[i].fault);
    end
    step();
    check("hold after fault valid", fetch_valid, 0);
    check("hold after fault instr", fetch_instr, NOP);

    // Pointer wrap from the last index back to 0.
    q = '{32'hA5A50001, 32'hA5A50002};
    load_burst("wrap", 32'h000000FC, q, 1'b0);
    fetch_chk("wrap hi", 32'h000000FC);
    fetch_chk("wrap lo", 32'h00000000);
    check("wrap lo const", model_mem[0], 32'hA5A50002);

    // Simultaneous fetch and load_start, then ignored load_start and refused fetch during LOAD.
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    load_start = 1'b1;
    load_base  = 32'h40;
    step();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    check("simul valid", fetch_valid, 1);
    check("simul instr", fetch_instr, 32'h019806B3);
    check("simul busy", load_busy, 1);
    check("load fready", fetch_ready, 0);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    check("load no fetch", fetch_valid, 0);
    load_start = 1'b1;
    load_base  = 32'h80;
    load_valid = 1'b1;
    load_data  = 32'h11112222;
    step();
    load_start = 1'b0;
    load_data  = 32'h33334444;
    load_last  = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    model_mem[16] = 32'h11112222;
    model_mem[17] = 32'h33334444;
    check("simul burst end", load_busy, 0);
    fetch_chk("ign start 0", 32'h40);
    fetch_chk("ign start 1", 32'h44);

    // Reset in the middle of a five-word burst keeps the words already written.
    load_start = 1'b1;
    load_base  = 32'h0;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hC0DE0000 + i;
      step();
      model_mem[i] = 32'hC0DE0000 + i;
    end
    load_data = 32'hDEADBEEF;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    load_valid = 1'b0;
    step();
    #2;
    reset = 1'b0;
    step();
    check_reset_outputs("postreset");
    for (int i = 0; i < 3; i++) fetch_chk("keep", 32'(i * 4));

    // Randomized traffic against the array model.
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
    load_burst("full", 32'h80 | 32'($urandom_range(0, 3)), q, 1'b1);
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        fetch_chk("rnd fetch", 32'($urandom_range(0, DEPTH - 1) * 4));
      end else if (r < 8) begin
        fetch_chk("rnd any", (r == 6) ? 32'($urandom_range(0, DEPTH * 4 + 64)) : $urandom);
      end else begin
        q.delete();
        for (int k = 0; k < $urandom_range(1, 5); k++) q.push_back($urandom);
        load_burst("rnd burst", $urandom, q, 1'b1);
      end
    end

`ifdef IMEM_PARITY_EN
    dut.u_sram.mem[5] = dut.u_sram.mem[5] ^ 33'h8;
    fetch_req  = 1'b1;
    fetch_addr = 32'h14;
    step();
    fetch_req = 1'b0;
    check("par valid", fetch_valid, 1);
    check("par err", par_err, 1);
    check("par data", fetch_instr, model_mem[5] ^ 32'h8);
    step();
    check("par drop", par_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, storage size in XLEN-bit words; power of two, 4..65536.
REQ-002 Parameter XLEN, default 32, instruction word width.
REQ-003 Parameter ADDR_W, default 32, byte-address width.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port fetch_req  input  1  fetch request.
REQ-007 Port fetch_addr  input  ADDR_W  fetch byte address.
REQ-008 Port fetch_ready  output  1  fetch can be accepted this cycle.
REQ-009 Port fetch_valid  output  1  fetch response valid.
REQ-010 Port fetch_instr  output  XLEN  fetched instruction.
REQ-011 Port fetch_fault  output  1  response is misaligned or out of range.
REQ-012 Port load_start  input  1  begin a program-load burst.
REQ-013 Port load_base  input  ADDR_W  burst start byte address, sampled with load_start.
REQ-014 Port load_valid  input  1  load_data is valid.
REQ-015 Port load_data  input  XLEN  word to write.
REQ-016 Port load_last  input  1  final word of the burst.
REQ-017 Port load_ready  output  1  loader word accepted this cycle.
REQ-018 Port load_busy  output  1  controller is in LOAD.
REQ-019 Port par_err  output  1  parity error on the current response; present only with IMEM_PARITY_EN.

Function
REQ-020 The FSM SHALL have two states: IDLE and LOAD.
REQ-021 In IDLE: fetch_ready=1 and load_ready=0. In LOAD: fetch_ready=0, load_ready=1 and load_busy=1.
REQ-022 A fetch is accepted on fetch_req&fetch_ready. Its response SHALL appear exactly 1 cycle later with fetch_valid=1 for one cycle.
REQ-023 The word index SHALL be fetch_addr>>2, i.e. byte addressing with 4-byte instruction stride.
REQ-024 fetch_fault=1 SHALL be set when fetch_addr[1:0]!=0 or when the index is >=DEPTH. In that case fetch_instr=32'h00000013 (NOP), and memory is not read.
REQ-025 Otherwise fetch_instr SHALL equal the stored word and fetch_fault=0.
REQ-026 When fetch_valid=0, fetch_instr SHALL hold its last value.
REQ-027 load_start in IDLE SHALL move the FSM to LOAD on the next cycle and set the write pointer to load_base>>2 modulo DEPTH. load_base[1:0] is ignored.
REQ-028 In LOAD, each load_valid cycle SHALL write load_data at the pointer and then increment it. The pointer wraps from DEPTH-1 to 0.
REQ-029 load_valid&load_last SHALL write the final word and return the FSM to IDLE on the next cycle.
REQ-030 load_start asserted during LOAD SHALL be ignored.
REQ-031 If fetch_req and load_start are both asserted in IDLE, the fetch SHALL be accepted and its response delivered; LOAD is entered on the following cycle.
REQ-032 A write followed by a fetch of the same word SHALL return the new data.

Reset
REQ-033 Reset SHALL force: state=IDLE, fetch_valid=0, fetch_instr=0, fetch_fault=0, load_busy=0, pointer=0, par_err=0.
REQ-034 Storage contents SHALL NOT be cleared by reset. A reset during LOAD aborts the burst and keeps words already written.

Configuration
REQ-035 With IMEM_PARITY_EN defined, each word SHALL store an extra even-parity bit computed on write.
REQ-036 With IMEM_PARITY_EN defined, a non-faulting read whose parity mismatches SHALL assert par_err together with fetch_valid; the data is returned unchanged.
REQ-037 Without IMEM_PARITY_EN, there SHALL be no parity storage and no par_err port.

Structure
REQ-038 A shared package imem_pkg SHALL hold: the state enum (IDLE, LOAD), the NOP constant 32'h00000013, and the instruction-stride constant 4.
REQ-039 Storage SHALL be a separate sub-module imem_sram: single write port, one-cycle synchronous read port, write-first on the same address.

Verification
REQ-040 Load burst base 0x0, words 0x00948663, 0x01980 6B3 (last) -> load_busy high for 2 cycles; then fetch 0x4 -> fetch_instr=0x019806B3 one cycle later.
REQ-041 Fetch 0x6 -> fetch_valid=1, fetch_fault=1, fetch_instr=0x00000013.
REQ-042 DEPTH=64, fetch 0x100 -> fetch_fault=1. Load with base 0xFC and 2 words -> second word lands at index 0.
REQ-043 Same-cycle fetch_req and load_start in IDLE -> fetch response next cycle, load_busy rises one cycle after.
REQ-044 Reset asserted mid-burst after 3 of 5 words -> IDLE and all outputs at reset values; fetch of indices 0..2 returns the loaded words.
REQ-045 IMEM_PARITY_EN: force a flipped bit in a stored word -> fetch of that word asserts par_err=1 with fetch_valid.
